// File: rtl/alu_serial_seq_pkg.sv
// Shared types for the bit-serial ALU sequencer: op encodings, FSM states and op decode.
package alu_serial_seq_pkg;

  typedef enum logic [1:0] {
    OP_XOR = 2'b00,
    OP_AND = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_RESP
  } seq_state_e;

  function automatic logic is_arith(input alu_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/alu_serial_seq_if.sv
// Request/response bus between the issue logic (master) and the serial ALU sequencer (slave).
import alu_serial_seq_pkg::*;

interface alu_serial_seq_if #(parameter int WIDTH = 8) ();
  logic             req_valid;
  logic             req_ready;
  alu_op_e          req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_cout;
  logic             rsp_ovf;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_cout, rsp_ovf
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_cout, rsp_ovf
  );
endinterface

// File: rtl/alu_serial_seq_capture.sv
// LSB-first reassembly register: each shift inserts at the MSB, so after WIDTH shifts
// the first bit received sits at bit 0.
module alu_serial_seq_capture #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word
);

  logic [WIDTH-1:0] word_q, word_d;

  always_comb begin
    word_d = word_q;
    if (clear)
      word_d = '0;
    else if (shift_en)
      word_d = {bit_in, word_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst)
      word_q <= '0;
    else
      word_q <= word_d;
  end

  assign word = word_q;

endmodule

// File: rtl/alu_serial_seq.sv
// Sequencer for the 1-bit RSFQ ALU slice: streams one operation LSB-first into the slice,
// reassembles the Sum stream and returns result, carry-out and signed overflow.
module alu_serial_seq
  import alu_serial_seq_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ALU_LAT = 5
) (
  input  logic gclk,
  input  logic rst,
  alu_serial_seq_if.slave bus,
  output logic alu_x,
  output logic alu_y,
  output logic alu_carry_in,
  output logic alu_end,
  output logic alu_cmpl_x,
  output logic alu_cmpl_y,
  output logic alu_op_xor,
  output logic alu_op_and,
  output logic alu_op_arith,
  input  logic alu_sum,
  input  logic alu_carry_out,
  input  logic alu_overflow
);

  localparam int CNT_W = $clog2(WIDTH + ALU_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0] ISSUE_END  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CAP_FIRST  = CNT_W'(ALU_LAT);
  localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(WIDTH + ALU_LAT - 1);

  seq_state_e       state_q, state_d;
  alu_op_e          op_q, op_d, dec_op;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] cap_cnt_q, cap_cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic rsp_cout_q, rsp_cout_d, rsp_ovf_q, rsp_ovf_d;
  logic x_q, x_d, y_q, y_d, cin_q, cin_d, end_q, end_d, cmpl_y_q, cmpl_y_d;
  logic op_xor_q, op_xor_d, op_and_q, op_and_d, op_arith_q, op_arith_d;
  logic issue_now, bit_x, bit_y, bit_first, bit_last;
  logic cap_clear, cap_shift;
  logic [WIDTH-1:0] cap_word;

  // The op being issued comes straight off the bus on the accept cycle, from the latch afterwards.
  assign dec_op = (state_q == ST_IDLE) ? bus.req_op : op_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    issue_cnt_d = issue_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_ovf_d   = rsp_ovf_q;
    issue_now   = 1'b0;
    bit_x       = 1'b0;
    bit_y       = 1'b0;
    bit_first   = 1'b0;
    bit_last    = 1'b0;
    cap_clear   = 1'b0;
    cap_shift   = 1'b0;

    case (state_q)
      ST_FLUSH: begin
        cap_cnt_d = cap_cnt_q + CNT_ONE;
        if (cap_cnt_q == FLUSH_LAST) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
          cap_cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          state_d     = ST_ISSUE;
          req_ready_d = 1'b0;
          op_d        = bus.req_op;
          a_sh_d      = bus.req_a >> 1;
          b_sh_d      = bus.req_b >> 1;
          issue_cnt_d = CNT_ONE;
          cap_cnt_d   = '0;
          cap_clear   = 1'b1;
          rsp_cout_d  = 1'b0;
          rsp_ovf_d   = 1'b0;
          issue_now   = 1'b1;
          bit_x       = bus.req_a[0];
          bit_y       = bus.req_b[0];
          bit_first   = 1'b1;
        end
      end
      ST_ISSUE, ST_DRAIN: begin
        if (state_q == ST_ISSUE) begin
          if (issue_cnt_q < ISSUE_END) begin
            issue_now   = 1'b1;
            bit_x       = a_sh_q[0];
            bit_y       = b_sh_q[0];
            bit_last    = (issue_cnt_q == BIT_LAST);
            a_sh_d      = a_sh_q >> 1;
            b_sh_d      = b_sh_q >> 1;
            issue_cnt_d = issue_cnt_q + CNT_ONE;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        // Capture trails issue by the slice latency, so it keeps its own count from accept.
        cap_cnt_d = cap_cnt_q + CNT_ONE;
        if (cap_cnt_q >= CAP_FIRST)
          cap_shift = 1'b1;
        if (cap_cnt_q == CAP_LAST) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_cout_d  = is_arith(op_q) & alu_carry_out;
          rsp_ovf_d   = is_arith(op_q) & alu_overflow;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = ST_FLUSH;
    endcase
  end

  always_comb begin
    x_d        = 1'b0;
    y_d        = 1'b0;
    cin_d      = 1'b0;
    end_d      = 1'b0;
    cmpl_y_d   = 1'b0;
    op_xor_d   = 1'b0;
    op_and_d   = 1'b0;
    op_arith_d = 1'b0;
    if (issue_now) begin
      x_d        = bit_x;
      y_d        = bit_y;
      end_d      = bit_last;
      op_xor_d   = (dec_op == OP_XOR);
      op_and_d   = (dec_op == OP_AND);
      op_arith_d = is_arith(dec_op);
      cmpl_y_d   = (dec_op == OP_SUB);
      cin_d      = bit_first && (dec_op == OP_SUB);
    end
  end

  always_ff @(posedge gclk) begin
    if (rst) begin
      state_q     <= ST_FLUSH;
      op_q        <= OP_XOR;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_cout_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      x_q         <= 1'b0;
      y_q         <= 1'b0;
      cin_q       <= 1'b0;
      end_q       <= 1'b0;
      cmpl_y_q    <= 1'b0;
      op_xor_q    <= 1'b0;
      op_and_q    <= 1'b0;
      op_arith_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_ovf_q   <= rsp_ovf_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cin_q       <= cin_d;
      end_q       <= end_d;
      cmpl_y_q    <= cmpl_y_d;
      op_xor_q    <= op_xor_d;
      op_and_q    <= op_and_d;
      op_arith_q  <= op_arith_d;
    end
  end

  alu_serial_seq_capture #(.WIDTH(WIDTH)) u_capture (
    .clk      (gclk),
    .rst      (rst),
    .clear    (cap_clear),
    .shift_en (cap_shift),
    .bit_in   (alu_sum),
    .word     (cap_word)
  );

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = cap_word;
  assign bus.rsp_cout   = rsp_cout_q;
  assign bus.rsp_ovf    = rsp_ovf_q;
  assign alu_x          = x_q;
  assign alu_y          = y_q;
  assign alu_carry_in   = cin_q;
  assign alu_end        = end_q;
  assign alu_cmpl_x     = 1'b0;
  assign alu_cmpl_y     = cmpl_y_q;
  assign alu_op_xor     = op_xor_q;
  assign alu_op_and     = op_and_q;
  assign alu_op_arith   = op_arith_q;

endmodule
